id_ex_pipe: RTL

Parametrised ID→EX pipeline stage for the CPU core. It carries the decoded ALU operation, operands and write-back destination from decode to execute, as the current fixed stall-less register does. It adds a valid/ready handshake, synchronous flush for branch/exception squash, and an optional 2-entry skid buffer that registers the upstream ready. A bubble counter records cycles in which execute waited on decode.

---
 rtl/id_ex_pipe_pkg.sv | 22 ++
 rtl/pipe_skid_reg.sv | 35 +++
 rtl/id_ex_pipe.sv | 133 +++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_pkg.sv
// Shared encodings and default widths for the ID->EX pipeline stage.
// NOP encodings are what an invalid/bubble entry drives toward execute,
// so a bubble never writes back.
package id_ex_pipe_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ALUOP_W  = 8;
  localparam int DEF_ALUSEL_W = 3;
  localparam int DEF_RADDR_W  = 5;
  localparam int DEF_CNT_W    = 16;

  localparam int EXE_NOP_OP  = 0;
  localparam int EXE_RES_NOP = 0;
  localparam int NOPRegAddr  = 0;

  // Width of the flat payload {aluop, alusel, reg1, reg2, wd, wreg}
  function automatic int payload_w(input int data_w, input int aluop_w,
                                   input int alusel_w, input int raddr_w);
    return data_w * 2 + aluop_w + alusel_w + raddr_w + 1;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/data holding register with load and clear.
// An invalid load or a clear parks the data at the supplied NOP value so
// that downstream never sees stale payload on a bubble.
module pipe_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  input  logic [W-1:0] nop_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic         vld_q;
  logic [W-1:0] data_q;

  // Hold entry; clear/reset wins over load, invalid loads become NOP
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      vld_q  <= 1'b0;
      data_q <= nop_i;
    end else if (ld_i) begin
      vld_q  <= vld_i;
      data_q <= vld_i ? data_i : nop_i;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline stage with valid/ready handshake, synchronous flush and
// a saturating bubble counter (cycles where execute waited on decode).
// Build option PIPE_SKID_EN: adds a second (skid) entry and registers
// in_ready so there is no combinational path from out_ready to in_ready.
// Without it, a single register with in_ready = !out_valid || out_ready.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ALUOP_W    = DEF_ALUOP_W,
  parameter int ALUSEL_W   = DEF_ALUSEL_W,
  parameter int RADDR_W    = DEF_RADDR_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int NOP_ALUOP  = EXE_NOP_OP,
  parameter int NOP_ALUSEL = EXE_RES_NOP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUOP_W-1:0]  in_aluop,
  input  logic [ALUSEL_W-1:0] in_alusel,
  input  logic [DATA_W-1:0]   in_reg1,
  input  logic [DATA_W-1:0]   in_reg2,
  input  logic [RADDR_W-1:0]  in_wd,
  input  logic                in_wreg,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUOP_W-1:0]  out_aluop,
  output logic [ALUSEL_W-1:0] out_alusel,
  output logic [DATA_W-1:0]   out_reg1,
  output logic [DATA_W-1:0]   out_reg2,
  output logic [RADDR_W-1:0]  out_wd,
  output logic                out_wreg,
  output logic [CNT_W-1:0]    bubble_cnt
);

  localparam int PW = payload_w(DATA_W, ALUOP_W, ALUSEL_W, RADDR_W);

  localparam logic [PW-1:0] NOP_PL = {ALUOP_W'(NOP_ALUOP), ALUSEL_W'(NOP_ALUSEL),
                                      {(2 * DATA_W){1'b0}}, RADDR_W'(NOPRegAddr), 1'b0};

  logic [PW-1:0] in_pl;
  logic [PW-1:0] main_din;
  logic [PW-1:0] main_data;
  logic          main_vld;
  logic          main_vin;
  logic          main_ld;
  logic          in_fire;
  logic          out_fire;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign in_pl    = {in_aluop, in_alusel, in_reg1, in_reg2, in_wd, in_wreg};
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_vld && out_ready;
  assign main_ld  = !main_vld || out_fire;

`ifdef PIPE_SKID_EN
  logic [PW-1:0] skid_data;
  logic          skid_vld;
  logic          skid_vin;
  logic          skid_ld;
  logic          skid_vld_d;
  logic          rdy_q;

  // Skid catches a beat only when main is full and not draining;
  // it empties whenever main reloads from it.
  assign skid_vin   = in_fire && main_vld && !out_fire;
  assign skid_ld    = skid_vin || (main_ld && skid_vld);
  assign skid_vld_d = flush ? 1'b0 : (skid_ld ? skid_vin : skid_vld);

  // Skid has priority so payload order is preserved
  assign main_vin = skid_vld || in_fire;
  assign main_din = skid_vld ? skid_data : in_pl;

  pipe_skid_reg #(.W(PW)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (flush),
    .ld_i   (skid_ld),
    .vld_i  (skid_vin),
    .data_i (in_pl),
    .nop_i  (NOP_PL),
    .vld_o  (skid_vld),
    .data_o (skid_data)
  );

  // Registered ready tracks the next-cycle skid occupancy
  always_ff @(posedge clk) begin
    if (rst) rdy_q <= 1'b1;
    else     rdy_q <= !skid_vld_d;
  end

  assign in_ready = rdy_q;
`else
  assign main_vin = in_fire;
  assign main_din = in_pl;
  assign in_ready = !main_vld || out_ready;
`endif

  pipe_skid_reg #(.W(PW)) u_main (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (flush),
    .ld_i   (main_ld),
    .vld_i  (main_vin),
    .data_i (main_din),
    .nop_i  (NOP_PL),
    .vld_o  (main_vld),
    .data_o (main_data)
  );

  assign out_valid = main_vld;
  assign {out_aluop, out_alusel, out_reg1, out_reg2, out_wd, out_wreg} = main_data;

  // Next bubble count: execute ready but starved, saturating at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (out_ready && !main_vld && !flush && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Bubble counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bubble_cnt = cnt_q;

endmodule
